// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode and operand-fetch stage feeding the ALU
module alu_operand_stage #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opcode,
    output logic [31:0] out_op_one,
    output logic [31:0] out_op_two,
    output logic [3:0]  out_rd,
    output logic        illegal
);

    logic [31:0] regFile [NREGS];

    logic [5:0]  opcode;
    logic [3:0]  rdIdx;
    logic [3:0]  rs1Idx;
    logic [3:0]  rs2Idx;
    logic [13:0] imm14;
    logic [25:0] imm26;

    assign opcode = in_instr[31:26];
    assign rdIdx  = in_instr[25:22];
    assign rs1Idx = in_instr[21:18];
    assign rs2Idx = in_instr[17:14];
    assign imm14  = in_instr[13:0];
    assign imm26  = in_instr[25:0];

    // Same-cycle write-back wins over the stored value; R0 is hardwired to zero.
    function automatic logic [31:0] bypassRead(input logic [3:0] idx, input logic [31:0] stored,
                                               input logic wbEn, input logic [3:0] wbAddr,
                                               input logic [31:0] wbData);
        if (idx == 4'd0)
            return 32'd0;
        else if (wbEn && wbAddr == idx)
            return wbData;
        else
            return stored;
    endfunction

    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] rdVal;

    assign rs1Val = bypassRead(rs1Idx, regFile[rs1Idx], wb_en, wb_addr, wb_data);
    assign rs2Val = bypassRead(rs2Idx, regFile[rs2Idx], wb_en, wb_addr, wb_data);
    assign rdVal  = bypassRead(rdIdx, regFile[rdIdx], wb_en, wb_addr, wb_data);

    logic        isLegal;
    logic [31:0] nextOne;
    logic [31:0] nextTwo;
    logic [3:0]  nextRd;

    always_comb begin
        isLegal = 1'b1;
        nextOne = rs1Val;
        nextTwo = rs2Val;
        nextRd  = rdIdx;
        case (opcode)
            6'd0, 6'd1, 6'd2: ;
            6'd3: nextTwo = {18'd0, imm14};
            6'd4, 6'd5, 6'd6, 6'd7: nextTwo = {{18{imm14[13]}}, imm14};
            6'd8, 6'd9, 6'd10, 6'd11: begin
                nextTwo = rdVal;
                nextRd  = 4'd0;
            end
            6'd12, 6'd13: begin
                nextOne = in_pc;
                nextTwo = {{6{imm26[25]}}, imm26};
                nextRd  = (opcode == 6'd13) ? 4'd15 : 4'd0;
            end
            default: isLegal = 1'b0;
        endcase
    end

    logic accept;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regFile[i] <= 32'd0;
        end else if (wb_en && wb_addr != 4'd0) begin
            regFile[wb_addr] <= wb_data;
        end
    end

    // Illegal opcodes are consumed but never forwarded, so they also drop out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            out_opcode <= 6'd0;
            out_op_one <= 32'd0;
            out_op_two <= 32'd0;
            out_rd     <= 4'd0;
        end else begin
            illegal <= accept && !isLegal;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= isLegal;
                if (isLegal) begin
                    out_opcode <= opcode;
                    out_op_one <= nextOne;
                    out_op_two <= nextTwo;
                    out_rd     <= nextRd;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode and operand-fetch pipeline stage that sits directly upstream of the ALU. It accepts one 32-bit instruction per cycle and decodes it. It reads the 16×32 register file it contains, with write-back bypass, and forms the immediates. It then presents a registered `{opcode, operandOne, operandTwo, rd}` bundle to the ALU under a valid/ready handshake. Write-back from the downstream stage enters through a dedicated port.

## Interface
- `NREGS`, 16: register count; R0 reads as zero and ignores writes.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_instr`/`in_pc` valid.
- `in_ready`  out  1: stage accepts this cycle.
- `in_instr`  in  32: fields are opcode[31:26], rd[25:22], rs1[21:18], rs2[17:14], imm14[13:0], imm26[25:0].
- `in_pc`  in  32: address of `in_instr`.
- `wb_en`  in  1: register write enable.
- `wb_addr`  in  4: write register index.
- `wb_data`  in  32: write data.
- `flush`  in  1: discard held and incoming instruction.
- `out_valid`  out  1: bundle valid to ALU.
- `out_ready`  in  1: downstream accepts.
- `out_opcode`  out  6: ALU opcode.
- `out_op_one`  out  32: ALU operandOne.
- `out_op_two`  out  32: ALU operandTwo.
- `out_rd`  out  4: destination register.
- `illegal`  out  1: one-cycle pulse when an opcode > 13 is accepted.

## Operation
- Handshake: `in_ready = !flush && (!out_valid || out_ready)`. An instruction is accepted when `in_valid && in_ready`.
- Operand selection on accept, with R[x] meaning bypassed read:
  - Opcodes 0–2 (R-type): op_one=R[rs1], op_two=R[rs2], rd=rd.
  - Opcode 3 (ANDI): op_two = imm14 zero-extended.
  - Opcodes 4–7 (ADDI, LW, LWPOI, SW): op_two = imm14 sign-extended from bit 13.
  - For opcodes 3–7: op_one=R[rs1], rd=rd.
  - Opcodes 8–11 (compare and branch): op_one=R[rs1], op_two=R[rd], rd=0.
  - Opcode 12 (J): op_one=`in_pc`, op_two = imm26 sign-extended from bit 25, rd=0.
  - Opcode 13 (CALL): same operands as J, rd=15.
  - Opcodes 14–63: not forwarded. `out_valid` is not set; `illegal` pulses high for the next cycle.
- Register read: R0 always reads 0. Otherwise, if `wb_en && wb_addr==idx && wb_addr!=0`, the read returns `wb_data` (same-cycle bypass). Otherwise it returns the array value.
- Register write: on a rising edge with `wb_en && wb_addr!=0`. Writes proceed regardless of stall or flush.
- Output register:
  - Loads on accept.
  - On `out_valid && out_ready` with no accept, `out_valid` clears.
  - While `out_valid && !out_ready`, all `out_*` hold stable.
- Flush: on the next edge `out_valid` clears. No instruction is accepted in the flush cycle. Data fields may hold stale values.
- Arithmetic is pure bit routing with no adders. The stage has no PC increment; sequencing belongs to fetch.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 instruction per cycle when `out_ready` is held high.
- Reset (asynchronous, mid-operation allowed):
  - Outputs: `out_valid`, `illegal`, `out_opcode`, `out_op_one`, `out_op_two` and `out_rd` all go to 0.
  - All registers R0–R15 clear to 0.
  - An in-flight bundle is lost.
- If an accept and a downstream consume happen in the same edge, the new bundle replaces the old one and `out_valid` stays 1.
- `flush` together with `in_valid` in the same cycle: flush wins and the input is not accepted (`in_ready`=0).
- A write-back and an accept reading the same register in the same cycle: the accepted bundle carries `wb_data`.
- `illegal` is high for exactly one cycle per illegal accept. Back-to-back illegal accepts keep it high.

## Test plan
- Write R1=5 and R2=7 via wb. Accept `in_instr`=0x04C48000 (ADD rd3 rs1 1 rs2 2) → next cycle: `out_valid`=1, opcode 1, op_one 5, op_two 7, rd 3.
- ADDI with imm14=0x3FFF → op_two 0xFFFFFFFF. ANDI with imm14=0x3FFF → op_two 0x00003FFF. CALL with `in_pc`=0x100 and imm26=0x3FFFFFE → op_one 0x100, op_two 0xFFFFFFFE, rd 15.
- Same-cycle bypass: `wb_en`, `wb_addr`=1, `wb_data`=0xDEADBEEF while accepting ADD rs1=1 → op_one 0xDEADBEEF. A write to R0 followed by a read of R0 returns 0.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid` high → `in_ready`=0 and outputs stable. `out_ready`=1 → the next instruction appears one cycle later with no loss or duplication.
- Opcode 14 accepted → `illegal`=1 for one cycle and `out_valid` stays 0. `flush` while `out_valid`=1 and `out_ready`=0 → `out_valid`=0 next cycle.
- Assert `reset` mid-stream between clock edges → outputs go to 0 immediately. After release, a read of R1 returns 0.
